// File: rtl/pll_apb_cfg.sv
// Single-transfer APB master for the PLL reconfiguration port.
// A host command runs one SETUP/ACCESS handshake and returns data or a timeout flag.
module pll_apb_cfg #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  err_cnt,
    output logic        apb_sel,
    output logic        apb_en,
    output logic        apb_write,
    output logic [4:0]  apb_addr,
    output logic [15:0] apb_wdata,
    input  logic [15:0] apb_rdata,
    input  logic        apb_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    state_t      state;
    state_t      state_next;
    logic        out_of_reset;
    logic        hold_write;
    logic [4:0]  hold_addr;
    logic [15:0] hold_wdata;
    logic [7:0]  wait_cnt;
    logic        accept;
    logic        ready_hit;
    logic        timeout_hit;

    // out_of_reset keeps cmd_ready low until one clean edge has passed after reset
    assign cmd_ready   = (state == IDLE) & out_of_reset & ~rst;
    assign accept      = cmd_valid & cmd_ready;
    assign busy        = (state != IDLE);
    assign rsp_valid   = (state == RESP);
    assign ready_hit   = (state == ACCESS) & apb_ready;
    assign timeout_hit = (state == ACCESS) & ~apb_ready & (wait_cnt == TIMEOUT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            out_of_reset <= 1'b0;
        end else begin
            state        <= state_next;
            out_of_reset <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        apb_sel    = 1'b0;
        apb_en     = 1'b0;
        apb_write  = 1'b0;
        apb_addr   = 5'd0;
        apb_wdata  = 16'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                apb_sel    = 1'b1;
                apb_write  = hold_write;
                apb_addr   = hold_addr;
                apb_wdata  = hold_wdata;
                state_next = ACCESS;
            end
            ACCESS: begin
                apb_sel   = 1'b1;
                apb_en    = 1'b1;
                apb_write = hold_write;
                apb_addr  = hold_addr;
                apb_wdata = hold_wdata;
                if (ready_hit || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_write <= 1'b0;
            hold_addr  <= 5'd0;
            hold_wdata <= 16'd0;
        end else if (accept) begin
            hold_write <= cmd_write;
            hold_addr  <= cmd_addr;
            hold_wdata <= cmd_wdata;
        end
    end

    // wait_cnt reads 1 during the first ACCESS cycle, so it equals the ACCESS cycle number
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (accept) begin
            wait_cnt <= 8'd0;
        end else if (state == SETUP) begin
            wait_cnt <= 8'd1;
        end else if ((state == ACCESS) && (state_next == ACCESS)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= 16'd0;
            rsp_err   <= 1'b0;
            err_cnt   <= 8'd0;
        end else if (ready_hit) begin
            rsp_rdata <= hold_write ? 16'd0 : apb_rdata;
            rsp_err   <= 1'b0;
        end else if (timeout_hit) begin
            rsp_rdata <= 16'd0;
            rsp_err   <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_apb_cfg.sv
// Randomized self-checking bench for pll_apb_cfg with a transaction-level reference model.
module tb_pll_apb_cfg;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  err_cnt;
    logic        apb_sel;
    logic        apb_en;
    logic        apb_write;
    logic [4:0]  apb_addr;
    logic [15:0] apb_wdata;
    logic [15:0] apb_rdata;
    logic        apb_ready;

    int checks = 0;
    int errors = 0;
    int acceptCnt = 0;
    int rspCnt = 0;
    int modelErrCnt = 0;

    pll_apb_cfg #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy),
        .err_cnt(err_cnt),
        .apb_sel(apb_sel),
        .apb_en(apb_en),
        .apb_write(apb_write),
        .apb_addr(apb_addr),
        .apb_wdata(apb_wdata),
        .apb_rdata(apb_rdata),
        .apb_ready(apb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acceptCnt++;
        if (rsp_valid) rspCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One host transfer; readyAt is the ACCESS cycle on which the PLL answers (0 = never)
    task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [15:0] wdata,
                                 input int readyAt, input logic [15:0] rdData, input logic holdValid);
        int acc;
        int acceptBefore;
        int expAcc;
        logic expErr;
        logic [15:0] expData;

        expErr  = (readyAt < 1) || (readyAt > TO);
        expAcc  = expErr ? TO : readyAt;
        expData = (wr || expErr) ? 16'd0 : rdData;
        if (expErr && modelErrCnt < 255) modelErrCnt++;
        acceptBefore = acceptCnt;

        @(negedge clk);
        checkOutput("idle_ready", cmd_ready, 1);
        checkOutput("idle_busy", busy, 0);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        apb_ready = 1'($urandom);

        @(negedge clk);
        checkOutput("setup_sel", apb_sel, 1);
        checkOutput("setup_en", apb_en, 0);
        checkOutput("setup_write", apb_write, wr);
        checkOutput("setup_addr", apb_addr, addr);
        checkOutput("setup_wdata", apb_wdata, wdata);
        checkOutput("setup_busy", busy, 1);
        checkOutput("setup_ready", cmd_ready, 0);
        if (holdValid) begin
            cmd_write = 1'($urandom);
            cmd_addr  = 5'($urandom);
            cmd_wdata = 16'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        apb_ready = 1'($urandom);

        acc = 0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (!apb_en) break;
            acc++;
            checkOutput("access_sel", apb_sel, 1);
            checkOutput("access_write", apb_write, wr);
            checkOutput("access_addr", apb_addr, addr);
            checkOutput("access_wdata", apb_wdata, wdata);
            apb_ready = (acc == readyAt);
            apb_rdata = (acc == readyAt) ? rdData : 16'($urandom);
        end

        checkOutput("access_cycles", acc, expAcc);
        checkOutput("resp_valid", rsp_valid, 1);
        checkOutput("resp_err", rsp_err, expErr);
        checkOutput("resp_rdata", rsp_rdata, expData);
        checkOutput("resp_sel", apb_sel, 0);
        checkOutput("resp_addr", apb_addr, 0);
        checkOutput("resp_wdata", apb_wdata, 0);
        checkOutput("resp_write", apb_write, 0);
        checkOutput("resp_errcnt", err_cnt, modelErrCnt);
        cmd_valid = 1'b0;
        apb_ready = 1'($urandom);
        apb_rdata = 16'($urandom);

        @(negedge clk);
        checkOutput("post_valid", rsp_valid, 0);
        checkOutput("post_busy", busy, 0);
        checkOutput("post_rdata", rsp_rdata, expData);
        checkOutput("post_err", rsp_err, expErr);
        checkOutput("accept_once", acceptCnt - acceptBefore, 1);
        apb_ready = 1'b0;
    endtask

    task automatic resetMidAccess();
        int rspBefore;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 5'($urandom);
        cmd_wdata = 16'($urandom);
        apb_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_access", apb_en, 1);
        rspBefore = rspCnt;
        rst = 1'b1;
        apb_ready = 1'b1;
        apb_rdata = 16'hBEEF;
        @(negedge clk);
        checkOutput("rst_sel", apb_sel, 0);
        checkOutput("rst_en", apb_en, 0);
        checkOutput("rst_addr", apb_addr, 0);
        checkOutput("rst_wdata", apb_wdata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rspvalid", rsp_valid, 0);
        checkOutput("rst_rdata", rsp_rdata, 0);
        checkOutput("rst_errflag", rsp_err, 0);
        checkOutput("rst_errcnt", err_cnt, 0);
        modelErrCnt = 0;
        rst = 1'b0;
        apb_ready = 1'b0;
        #1;
        checkOutput("rst_ready_early", cmd_ready, 0);
        @(negedge clk);
        checkOutput("rst_ready_after", cmd_ready, 1);
        checkOutput("rst_no_rsp", rspCnt - rspBefore, 0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = 5'd0;
        cmd_wdata = 16'd0;
        apb_rdata = 16'd0;
        apb_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", cmd_ready, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rspvalid", rsp_valid, 0);
        checkOutput("reset_errcnt", err_cnt, 0);
        checkOutput("reset_sel", apb_sel, 0);
        checkOutput("reset_rdata", rsp_rdata, 0);
        rst = 1'b0;
        #1;
        checkOutput("reset_ready_early", cmd_ready, 0);

        applyStimulus(1'b1, 5'h03, 16'hA55A, 1, 16'h7777, 1'b0);
        applyStimulus(1'b0, 5'h10, 16'h0000, 4, 16'h1234, 1'b0);
        applyStimulus(1'b0, 5'h07, 16'h0000, 0, 16'h5555, 1'b0);
        applyStimulus(1'b0, 5'h1F, 16'h0000, TO, 16'hC3C3, 1'b1);
        applyStimulus(1'b1, 5'h00, 16'hFFFF, TO + 1, 16'h0F0F, 1'b1);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'($urandom), 5'($urandom), 16'($urandom),
                          $urandom_range(0, 6), 16'($urandom), 1'($urandom));
        end

        resetMidAccess();
        applyStimulus(1'b0, 5'h0A, 16'h0000, 2, 16'h9ABC, 1'b0);

        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'($urandom), 5'($urandom), 16'($urandom), 0, 16'($urandom), 1'b1);
        end
        checkOutput("errcnt_saturated", err_cnt, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pll_apb_cfg.md
PLL_APB_CFG -- requirements
Module: pll_apb_cfg

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum number of ACCESS cycles waited for apb_ready before abort (legal 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock for all logic and for the APB bus.
REQ-003 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1, a host request to run one APB transfer.
REQ-005 SHALL have port cmd_ready, output, 1, which is high when a request is accepted this cycle.
REQ-006 SHALL have port cmd_write, input, 1, selecting the transfer type: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr, input, 5, the PLL register address.
REQ-008 SHALL have port cmd_wdata, input, 16, the write data.
REQ-009 SHALL have port rsp_valid, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 16, the read data, valid with rsp_valid.
REQ-011 SHALL have port rsp_err, output, 1, a timeout flag, valid with rsp_valid.
REQ-012 SHALL have port busy, output, 1, which is high in any state other than IDLE.
REQ-013 SHALL have port err_cnt, output, 8, a saturating count of timeouts.
REQ-014 SHALL have APB master outputs apb_sel (1), apb_en (1), apb_write (1), apb_addr (5) and apb_wdata (16), driving the PLL reconfiguration port.
REQ-015 SHALL have APB inputs apb_rdata (16) and apb_ready (1), driven by the PLL.

Function
REQ-016 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-017 SHALL assert cmd_ready only in IDLE, not in reset.
- Acceptance = cmd_valid & cmd_ready.
- On acceptance, cmd_write, cmd_addr and cmd_wdata SHALL be captured into holding registers.
REQ-018 SHALL make the transition IDLE->SETUP on acceptance; otherwise it stays in IDLE.
REQ-019 In SETUP: apb_sel=1, apb_en=0, and apb_write/apb_addr/apb_wdata come from the captured values; SETUP->ACCESS is unconditional after 1 cycle.
REQ-020 In ACCESS: apb_sel=1, apb_en=1, with the same address, data and write values; a wait counter increments every ACCESS cycle, and the first ACCESS cycle counts as 1.
REQ-021 In ACCESS with apb_ready=1: go to RESP.
- For a read, apb_rdata SHALL be latched into rsp_rdata.
- For a write, rsp_rdata SHALL be 0.
- rsp_err SHALL be 0.
REQ-022 In ACCESS with apb_ready=0 and wait counter == TIMEOUT_CYC: go to RESP with rsp_err=1 and rsp_rdata=0, and increment err_cnt, saturating at 255.
REQ-023 SHALL let apb_ready=1 on the timeout cycle take priority, giving a normal completion with no error.
REQ-024 In RESP: rsp_valid=1 for exactly 1 cycle, apb_sel=apb_en=0, then go to IDLE; rsp_valid SHALL have no backpressure.
REQ-025 SHALL hold apb_write, apb_addr and apb_wdata at 0 in IDLE and RESP.
REQ-026 SHALL meet the minimum latency:
- Acceptance at edge T gives SETUP at T+1 and ACCESS at T+2.
- apb_ready at T+2 gives rsp_valid at T+3.
- The next acceptance is possible at T+4.
REQ-027 SHALL hold rsp_rdata and rsp_err stable until the next RESP, and ignore them when rsp_valid=0.
REQ-028 SHALL ignore cmd_* while busy; the host holds cmd_valid until acceptance.
REQ-029 SHALL ignore apb_ready outside ACCESS.
REQ-030 SHALL clear the wait counter on entry to SETUP.

Reset
REQ-031 While rst=1 at a clock edge, the following SHALL all go to 0 on that edge: state=IDLE, cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, err_cnt, all apb_* outputs, and the wait counter.
REQ-032 On reset mid-transfer (SETUP/ACCESS/RESP), the transfer SHALL be abandoned with no rsp_valid, and the APB bus SHALL be released on the same edge.
REQ-033 SHALL assert cmd_ready no earlier than the first edge after rst deasserts.

Verification
REQ-034 A write of addr=5'h03, data=16'hA55A with apb_ready high in the first ACCESS cycle SHALL give:
- SETUP then ACCESS with apb_write=1;
- rsp_valid at T+3 with rsp_err=0 and rsp_rdata=0.
REQ-035 A read of addr=5'h10 with apb_ready after 3 wait cycles and apb_rdata=16'h1234 SHALL give rsp_rdata=16'h1234, rsp_err=0, and rsp_valid 1 cycle after the ready cycle.
REQ-036 With TIMEOUT_CYC=4, a read with apb_ready never high SHALL give:
- exactly 4 ACCESS cycles;
- rsp_err=1, rsp_rdata=0;
- err_cnt goes 0->1;
- the bus released in RESP.
REQ-037 With apb_ready asserted exactly on ACCESS cycle TIMEOUT_CYC, the transfer SHALL give rsp_err=0, data captured, and err_cnt unchanged.
REQ-038 rst=1 during ACCESS SHALL give all outputs 0 on the next edge and no rsp_valid; a new command is accepted after rst drops.
REQ-039 260 consecutive timeouts SHALL leave err_cnt saturated at 255, and cmd_valid held during busy SHALL be accepted only once per IDLE.
